multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the 32-bit MIPS-style datapath (8-bit PC) through fetch, decode, execute, memory and writeback.
- Generates every datapath control strobe per state.
- Waits on a memory-ready handshake.
- Counts retired instructions.
- Flags illegal opcodes and halts on them.
- Sits beside the datapath core; the datapath feeds back the instruction opcode.

Parameters:
COUNT_W, 16, width of the retired-instruction counter (wraps modulo 2^COUNT_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; high = execute instructions, low = stop at the next instruction boundary
opcode  input  6  instr[31:26] from the instruction register
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
iord  output  1  0 = memory address from PC, 1 = from ALU result register
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback data from memory data register
reg_dst  output  1  1 = rd, 0 = rt
reg_write  output  1  register file write
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
pc_src  output  2  00 ALU result, 01 ALU out register, 10 jump target
state  output  4  current state encoding, for debug
illegal  output  1  sticky illegal-opcode flag
instr_count  output  COUNT_W  retired instructions

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=13.
- Reset: state=IDLE; all strobes 0; all selects 0; illegal=0; instr_count=0. Reset mid-instruction aborts immediately, with no partial writeback.
- Control outputs are Moore (decoded from state), with one exception: in FETCH, ir_write, pc_write, alu_src_b=01 and pc_src=00 are gated by mem_ready.
- IDLE: outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, iord=0. Stay while mem_ready=0. When mem_ready=1: assert ir_write and pc_write (PC+4), then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> HALT
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready; sw retires on that cycle.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. lw retires.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. R-type retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. beq retires.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Then go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. addi retires.
- JUMP: pc_write=1, pc_src=10. j retires.
- Retire cycle:
  - instr_count increments by 1, wrapping at all-ones.
  - Next state is FETCH if run=1, else IDLE.
  - run is sampled only at retire or in IDLE, never mid-instruction.
- HALT: illegal=1; all strobes 0; no count increment. Leave only by reset.
- Latency with mem_ready=1 always: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles, FETCH to retire inclusive.
- Memory wait: each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Strobes hold steady while waiting.
- Mutual exclusion: mem_read and mem_write are never both 1; reg_write never coincides with mem_write.

Decomposition:
- Shared package/include: state localparams, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), alu_op and alu_src_b codes.
- Sub-module: control_decode, a combinational state -> strobes decoder. The FSM register, next-state logic and counter stay in the top module.

Test Plan:
- Reset held 2 cycles mid-EXEC, then released -> state=0, all strobes 0, instr_count=0, illegal=0.
- run=1, mem_ready=1, opcode=000000 -> state sequence 1,2,7,8,1; reg_write=1 and reg_dst=1 only in state 8; instr_count=1 after 4 cycles.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> sequence 1,2,3,4,4,4,4,5; mem_read/iord held steady; retires after 8 cycles.
- sw, beq, j, addi back-to-back -> 4+3+3+4=14 cycles; instr_count=4; pc_write_cond=1 only in BRANCH; pc_src=10 only in JUMP.
- opcode=111111 -> DECODE then HALT; illegal=1 persists with run toggling; count unchanged until reset.
- run dropped during MEMADR of lw -> instruction completes, then IDLE; count +1; with COUNT_W=4 preset at 15, one more retire wraps it to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS-style control FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state encodings, opcode constants, alu_op / alu_src_b / pc_src codes,
// the packed control-strobe bundle and the DECODE-stage opcode dispatch function.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT    = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath strobe/select in one bundle so the decoder drives a single port.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // State that follows DECODE for a given opcode; unknown opcodes halt.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_next = S_EXEC;
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_ADDI:      decode_next = S_ADDIEX;
      OP_J:         decode_next = S_JUMP;
      default:      decode_next = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> datapath strobe decoder.
// Latency: zero cycles (pure combinational).
// Backpressure: mem_ready only gates the FETCH-stage IR/PC load; other states are pure Moore.
// Ports: state (current FSM state), mem_ready (memory handshake), ctrl (strobe bundle).
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b0;
        // IR and PC+4 may only load once the fetched word is actually present.
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_b = ALUB_FOUR;
          ctrl.pc_src    = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into the ALU out register.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;   // IDLE, HALT: everything quiet
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 32-bit MIPS-style datapath: sequencing, retire count, illegal-op halt.
// Latency: FETCH->retire 3 (beq, j), 4 (R-type, sw, addi), 5 (lw) cycles with memory always ready.
// Backpressure: each mem_ready=0 cycle in FETCH/MEMRD/MEMWR stretches the instruction by one cycle, strobes held.
// Ports: clk, reset (sync, active-high), run, opcode, mem_ready in; datapath strobes/selects,
// state (debug), illegal (sticky) and instr_count out.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t cur;
  ctrl_t  ctrl;
  ctrl_t  ctrl_q;
  logic   retire;

  // Last cycle of every instruction; sw retires on its memory-ready cycle.
  always_comb begin
    retire = 1'b0;
    case (cur)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR:                                      retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_ONE;
      case (cur)
        S_IDLE:   if (run) cur <= S_FETCH;
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          cur <= decode_next(opcode);
          if (decode_next(opcode) == S_HALT) illegal <= 1'b1;
        end
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= run ? S_FETCH : S_IDLE;
        S_EXEC:   cur <= S_ALUWB;
        S_ADDIEX: cur <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                  cur <= run ? S_FETCH : S_IDLE;
        S_HALT:   cur <= S_HALT;
        default:  cur <= S_IDLE;
      endcase
    end
  end

  multicycle_control_decode u_decode (
    .state     (cur),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset silences every strobe in the same cycle so an interrupted
  // instruction cannot complete a partial register or memory write.
  assign ctrl_q = reset ? '0 : ctrl;

  assign pc_write      = ctrl_q.pc_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign iord          = ctrl_q.iord;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign ir_write      = ctrl_q.ir_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_src        = ctrl_q.pc_src;
  assign state         = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, counter width 4 so the wrap is reachable.
// Latency: n/a.
// Backpressure: mem_ready driven directly by the stimulus sequence.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic          illegal;
  logic [CW-1:0] instr_count;

  int compared   = 0;
  int mismatched = 0;

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .state         (state),
    .illegal       (illegal),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // All single-bit strobes plus selects, concatenated for "all quiet" checks.
  wire [15:0] all_strobes = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural exclusions, checked every cycle away from the clock edge.
  always @(negedge clk) begin
    compared++;
    assert (!(mem_read && mem_write)) else begin
      mismatched++;
      $error("FAIL rd_wr_excl observed=%0b%0b expected=not both", mem_read, mem_write);
    end
    compared++;
    assert (!(reg_write && mem_write)) else begin
      mismatched++;
      $error("FAIL regw_memw_excl observed=%0b%0b expected=not both", reg_write, mem_write);
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    tick();
    reset = 1'b0;
    chk("reset_state", 32'(state), 32'd0);

    // Reach EXEC, then reset for two cycles.
    run = 1'b1;
    tick(); chk("pre_fetch", 32'(state), 32'd1);
    tick(); chk("pre_decode", 32'(state), 32'd2);
    tick(); chk("pre_exec", 32'(state), 32'd7);
    chk("pre_exec_aluop", 32'(alu_op), 32'd2);
    reset = 1'b1;
    #1 chk("reset_gates_aluop", 32'(alu_op), 32'd0);
    tick(); tick();
    reset = 1'b0; run = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(all_strobes), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    tick(); chk("idle_hold", 32'(state), 32'd0);

    // R-type: 1,2,7,8,1
    run = 1'b1; opcode = 6'b000000;
    tick(); chk("r_fetch", 32'(state), 32'd1);
    chk("r_fetch_strb", {28'd0, mem_read, ir_write, pc_write, iord}, 32'b1110);
    chk("r_fetch_srcb", 32'(alu_src_b), 32'd1);
    chk("r_fetch_regw", 32'(reg_write), 32'd0);
    tick(); chk("r_decode", 32'(state), 32'd2);
    chk("r_decode_srcb", 32'(alu_src_b), 32'd3);
    chk("r_decode_srca", 32'(alu_src_a), 32'd0);
    tick(); chk("r_exec", 32'(state), 32'd7);
    chk("r_exec_sel", {27'd0, alu_src_a, alu_src_b, alu_op}, {27'd0, 1'b1, 2'b00, 2'b10});
    chk("r_exec_regw", 32'(reg_write), 32'd0);
    tick(); chk("r_aluwb", 32'(state), 32'd8);
    chk("r_aluwb_wr", {30'd0, reg_write, reg_dst}, 32'b11);
    chk("r_aluwb_cnt", 32'(instr_count), 32'd0);
    tick(); chk("r_refetch", 32'(state), 32'd1);
    chk("r_count", 32'(instr_count), 32'd1);

    // lw with three memory waits in MEMRD: 1,2,3,4,4,4,4,5
    opcode = 6'b100011;
    tick(); chk("lw_decode", 32'(state), 32'd2);
    tick(); chk("lw_memadr", 32'(state), 32'd3);
    chk("lw_memadr_sel", {27'd0, alu_src_a, alu_src_b, alu_op}, {27'd0, 1'b1, 2'b10, 2'b00});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_memrd_wait", 32'(state), 32'd4);
      chk("lw_memrd_strb", {30'd0, mem_read, iord}, 32'b11);
    end
    tick(); chk("lw_memrd_last", 32'(state), 32'd4);
    mem_ready = 1'b1;
    chk("lw_memrd_last_strb", {30'd0, mem_read, iord}, 32'b11);
    tick(); chk("lw_memwb", 32'(state), 32'd5);
    chk("lw_memwb_wr", {29'd0, reg_write, mem_to_reg, reg_dst}, 32'b110);
    tick(); chk("lw_refetch", 32'(state), 32'd1);
    chk("lw_count", 32'(instr_count), 32'd2);

    // FETCH stall: IR/PC load suppressed while memory not ready.
    mem_ready = 1'b0;
    #1 chk("fetch_stall_strb", {29'd0, mem_read, ir_write, pc_write}, 32'b100);
    tick(); chk("fetch_stall_state", 32'(state), 32'd1);
    mem_ready = 1'b1;

    // sw, beq, j, addi back-to-back.
    opcode = 6'b101011;
    tick(); chk("sw_decode", 32'(state), 32'd2);
    tick(); chk("sw_memadr", 32'(state), 32'd3);
    tick(); chk("sw_memwr", 32'(state), 32'd6);
    chk("sw_memwr_strb", {29'd0, mem_write, iord, mem_read}, 32'b110);
    tick(); chk("sw_refetch", 32'(state), 32'd1);
    chk("sw_count", 32'(instr_count), 32'd3);
    chk("sw_fetch_pwc", 32'(pc_write_cond), 32'd0);
    opcode = 6'b000100;
    tick(); chk("beq_decode", 32'(state), 32'd2);
    chk("beq_decode_pwc", 32'(pc_write_cond), 32'd0);
    tick(); chk("beq_branch", 32'(state), 32'd9);
    chk("beq_sel", {25'd0, pc_write_cond, pc_src, alu_op, alu_src_b},
        {25'd0, 1'b1, 2'b01, 2'b01, 2'b00});
    tick(); chk("beq_refetch", 32'(state), 32'd1);
    chk("beq_count", 32'(instr_count), 32'd4);
    opcode = 6'b000010;
    tick(); chk("j_decode", 32'(state), 32'd2);
    chk("j_decode_pcsrc", 32'(pc_src), 32'd0);
    tick(); chk("j_jump", 32'(state), 32'd12);
    chk("j_sel", {29'd0, pc_write, pc_src}, 32'b110);
    tick(); chk("j_refetch", 32'(state), 32'd1);
    chk("j_count", 32'(instr_count), 32'd5);
    opcode = 6'b001000;
    tick(); chk("addi_decode", 32'(state), 32'd2);
    tick(); chk("addi_ex", 32'(state), 32'd10);
    chk("addi_ex_sel", {27'd0, alu_src_a, alu_src_b, alu_op}, {27'd0, 1'b1, 2'b10, 2'b00});
    tick(); chk("addi_wb", 32'(state), 32'd11);
    chk("addi_wb_wr", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b100);
    tick(); chk("addi_refetch", 32'(state), 32'd1);
    chk("addi_count", 32'(instr_count), 32'd6);

    // Nine jumps bring the 4-bit counter to 15.
    opcode = 6'b000010;
    for (int i = 0; i < 9; i++) begin
      tick(); tick(); tick();
    end
    chk("jloop_state", 32'(state), 32'd1);
    chk("jloop_count", 32'(instr_count), 32'd15);

    // lw with run dropped in MEMADR: completes, wraps count, goes IDLE.
    opcode = 6'b100011;
    tick(); chk("lwr_decode", 32'(state), 32'd2);
    tick(); chk("lwr_memadr", 32'(state), 32'd3);
    run = 1'b0;
    tick(); chk("lwr_memrd", 32'(state), 32'd4);
    tick(); chk("lwr_memwb", 32'(state), 32'd5);
    chk("lwr_count_pre", 32'(instr_count), 32'd15);
    tick(); chk("lwr_idle", 32'(state), 32'd0);
    chk("lwr_wrap", 32'(instr_count), 32'd0);
    tick(); chk("lwr_idle_hold", 32'(state), 32'd0);

    // Illegal opcode halts, sticky across run toggling, cleared by reset.
    run = 1'b1; opcode = 6'b111111;
    tick(); chk("ill_fetch", 32'(state), 32'd1);
    tick(); chk("ill_decode", 32'(state), 32'd2);
    chk("ill_decode_flag", 32'(illegal), 32'd0);
    tick(); chk("ill_halt", 32'(state), 32'd13);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_strobes", 32'(all_strobes), 32'd0);
    run = 1'b0;
    tick(); chk("ill_hold_run0", 32'(state), 32'd13);
    run = 1'b1; opcode = 6'b000000;
    tick(); tick();
    chk("ill_hold_run1", 32'(state), 32'd13);
    chk("ill_flag_sticky", 32'(illegal), 32'd1);
    chk("ill_count", 32'(instr_count), 32'd0);
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_flag", 32'(illegal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
